// File: rtl/systolic_mxu.sv
// Output-stationary systolic array computing C = A*B (or C += A*B), with operand skew generated internally.
// o_valid pulses L+1 cycles after accept (L = K+ROWS+COLS-2); i_start is ignored while busy and accepted again in DONE.
module systolic_mxu #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W + $clog2(K),
  parameter int SIGNED = 0
) (
  input  logic                                 i_clk,
  input  logic                                 i_arst_n,
  input  logic                                 i_start,
  input  logic                                 i_acc,
  input  logic [ROWS-1:0][K-1:0][DATA_W-1:0]   i_a,
  input  logic [K-1:0][COLS-1:0][DATA_W-1:0]   i_b,
  output logic                                 o_ready,
  output logic                                 o_busy,
  output logic                                 o_valid,
  output logic [ROWS-1:0][COLS-1:0][ACC_W-1:0] o_c
);

  localparam int L  = K + ROWS + COLS - 2;
  localparam int TW = (L > 1) ? $clog2(L) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(L - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COMPUTE = 2'd1, S_DONE = 2'd2} state_e;

  state_e                                 state_q, state_d;
  logic [TW-1:0]                          t_q, t_d;
  logic [ROWS-1:0][K-1:0][DATA_W-1:0]     a_q;
  logic [K-1:0][COLS-1:0][DATA_W-1:0]     b_q;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]  a_op_q, a_op_d, b_op_q, b_op_d;
  logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]   acc_q, acc_d, acc_nxt, c_q, c_d;
  logic                                   accept, last;

  // Full-width product, sign- or zero-extended to the accumulator width.
  function automatic logic [ACC_W-1:0] mac_term(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] ps;
    logic        [2*DATA_W-1:0] pu;
    ps = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    pu = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    return (SIGNED != 0) ? ACC_W'(ps) : ACC_W'(pu);
  endfunction

  always_comb begin
    accept  = i_start && (state_q != S_COMPUTE);
    last    = (state_q == S_COMPUTE) && (t_q == T_LAST);
    state_d = state_q;
    t_d     = '0;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_COMPUTE;
      S_COMPUTE: begin
        if (last) state_d = S_DONE;
        else      t_d = t_q + 1'b1;
      end
      S_DONE:    state_d = accept ? S_COMPUTE : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // a_op_q/b_op_q hold the operands each PE multiplies this cycle; the edge
  // column/row is loaded with the skewed element for the following t.
  always_comb begin
    a_op_d = '0;
    b_op_d = '0;
    if (accept) begin
      a_op_d[0][0] = i_a[0][0];
      b_op_d[0][0] = i_b[0][0];
    end else if (state_q == S_COMPUTE && !last) begin
      for (int i = 0; i < ROWS; i++)
        for (int k = 0; k < K; k++)
          if (i + k == int'(t_q) + 1) a_op_d[i][0] = a_q[i][k];
      for (int j = 0; j < COLS; j++)
        for (int k = 0; k < K; k++)
          if (j + k == int'(t_q) + 1) b_op_d[0][j] = b_q[k][j];
      for (int i = 0; i < ROWS; i++)
        for (int j = 1; j < COLS; j++)
          a_op_d[i][j] = a_op_q[i][j-1];
      for (int i = 1; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          b_op_d[i][j] = b_op_q[i-1][j];
    end
  end

  always_comb begin
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        acc_nxt[i][j] = acc_q[i][j] + mac_term(a_op_q[i][j], b_op_q[i][j]);
    acc_d = acc_q;
    if (accept) begin
      if (!i_acc) acc_d = '0;
    end else if (state_q == S_COMPUTE) begin
      acc_d = acc_nxt;
    end
    c_d = last ? acc_nxt : c_q;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      a_op_q  <= '0;
      b_op_q  <= '0;
      acc_q   <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      a_op_q  <= a_op_d;
      b_op_q  <= b_op_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      if (accept) begin
        a_q <= i_a;
        b_q <= i_b;
      end
    end
  end

  assign o_ready = (state_q != S_COMPUTE);
  assign o_busy  = (state_q == S_COMPUTE);
  assign o_valid = (state_q == S_DONE);
  assign o_c     = c_q;

endmodule

// File: doc/systolic_mxu.md
# systolic_mxu

Parametrised output-stationary systolic matrix-multiply unit computing C = A·B, or C += A·B in accumulate mode. A is ROWS×K, B is K×COLS, and C is ROWS×COLS. It succeeds the fixed 4×4 array with four changes: dimensions and widths are generic, input skewing is generated internally from unskewed operand matrices, a start/busy/valid handshake is added, and a signed mode is added. It sits between the operand buffers and the result writeback in the matrix datapath.

## Interface
**Parameters**
- ROWS, 4: rows of A and C (≥1)
- COLS, 4: columns of B and C (≥1)
- K, 4: inner dimension (≥1)
- DATA_W, 8: operand element width
- ACC_W, 2*DATA_W+$clog2(K): accumulator and result element width
- SIGNED, 0: 0 means unsigned operands; 1 means two's-complement operands and results

**Ports**
- i_clk, in, 1: clock; all state updates on the rising edge
- i_arst_n, in, 1: asynchronous active-low reset
- i_start, in, 1: request a multiply; sampled only when o_ready=1
- i_acc, in, 1: sampled with an accepted i_start; 1 means accumulate onto the current accumulators, 0 means clear them first
- i_a, in, [ROWS][K][DATA_W]: matrix A, captured on the accept edge
- i_b, in, [K][COLS][DATA_W]: matrix B, captured on the accept edge
- o_ready, out, 1: high in IDLE and DONE
- o_busy, out, 1: high in COMPUTE
- o_valid, out, 1: one-cycle pulse when o_c is updated
- o_c, out, [ROWS][COLS][ACC_W]: registered result; held until the next o_valid

## Operation
- Define L = K+ROWS+COLS-2.
- The FSM has three states: IDLE, COMPUTE and DONE.
- **IDLE → COMPUTE:** on i_start=1. On the same edge:
  - capture i_a and i_b;
  - set cycle counter t to 0;
  - if i_acc=0, clear all accumulators.
- **COMPUTE:** t increments once per cycle.
  - Row edge i injects a[i][t-i] when 0 ≤ t-i < K, otherwise 0.
  - Column edge j injects b[t-j][j] when 0 ≤ t-j < K, otherwise 0.
  - Each PE(i,j) forwards its A operand right and its B operand down through one register each.
  - Each PE multiplies its operands and adds the product into its accumulator every cycle.
  - PE(i,j) therefore consumes k = t-i-j in cycle t.
- **COMPUTE → DONE:** when t = L-1. On this edge o_c loads all accumulators.
- **DONE:** lasts one cycle with o_valid=1.
  - If i_start=1 in DONE, go to COMPUTE with the same accept semantics as IDLE. This gives back-to-back operation with no gap.
  - Otherwise go to IDLE.
- i_start while o_busy=1 is ignored, not queued.
- **Arithmetic:**
  - Products are 2*DATA_W bits wide and sign- or zero-extended to ACC_W according to SIGNED.
  - Accumulation wraps modulo 2^ACC_W. With the default ACC_W no overflow is possible for a single multiply.
  - Injected zeros contribute nothing to the accumulators.
- Degenerate sizes (ROWS=1, COLS=1 or K=1) must elaborate and operate correctly. For 1×1×1, L=1.

## Timing
- **Reset values:**
  - FSM = IDLE;
  - o_ready=1, o_busy=0, o_valid=0;
  - o_c=0, all accumulators=0;
  - pipeline operand registers=0;
  - t=0.
- **Reset mid-COMPUTE:** aborts immediately. All of the above values apply, and no o_valid is produced for the aborted operation.
- **Latency:** with i_start accepted at edge E0, o_busy is high for cycles 1..L, o_valid is high in cycle L+1, and o_c is stable from cycle L+1. At default parameters L=10, so o_valid appears 11 cycles after the accept edge.
- **Throughput:** with back-to-back starts, one result every L+1 cycles.
- **Accumulate mode:** i_acc=1 adds onto the accumulator contents left by the previous operation. Those contents equal the last o_c, or 0 after reset.
- **o_c between updates:** o_c changes only on the edge entering DONE. During COMPUTE it holds the previous result.

## Test plan
- **Identity:** defaults, A = 4×4 identity, B[k][j]=4k+j+1, i_acc=0 → o_valid exactly 11 cycles after the start edge, with o_c[i][j] = B[i][j].
- **Unsigned saturation-free max:** all elements 255, SIGNED=0 → every o_c = 4·65025 = 260100, with no wrap at ACC_W=18.
- **Signed:** SIGNED=1, all A=-128, all B=127 → every o_c = -65024.
- **Back-to-back and accumulate:**
  - i_start held high, op1 with i_acc=0 and A=B=identity, op2 with i_acc=1 and the same operands;
  - → two o_valid pulses 11 cycles apart;
  - → second o_c = 2·identity;
  - → o_busy low only in the DONE cycle.
- **Start while busy and reset mid-op:**
  - pulse i_start at COMPUTE cycle 3 → ignored, and the result is unchanged;
  - assert i_arst_n=0 at COMPUTE cycle 5 → outputs go to their reset values asynchronously;
  - next start → correct result with no residue from the aborted operation.
- **Non-square:** ROWS=2, COLS=3, K=5, random operands (100 runs) → results match the reference model, with o_valid at cycle K+ROWS+COLS-1 = 9.
